// File: rtl/m_memarb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package m_memarb_pkg;

    localparam int unsigned AW_DEF = 12;
    localparam int unsigned DW_DEF = 32;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned GNT_D = 0;
    localparam int unsigned GNT_I = 1;
    localparam int unsigned GNT_L = 2;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_LOCK,
        ST_HOLDOFF
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_D,
        OWN_I,
        OWN_L
    } owner_e;

    // True when two or more of the three requesters are active.
    function automatic logic multi_req(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/m_memarb_if.sv
// Requester and RAM-side bus of the memory arbiter.
interface m_memarb_if
    import m_memarb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;

    logic          l_req;
    logic          l_lock;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_rvalid;

    logic [DW-1:0] rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        input  i_req, i_addr,
        input  l_req, l_lock, l_we, l_addr, l_wdata,
        input  mem_dout,
        output d_gnt, d_rvalid, i_gnt, i_rvalid, l_gnt, l_rvalid,
        output rdata, mem_addr, mem_we, mem_din
    );

    modport master (
        output d_req, d_we, d_addr, d_wdata,
        output i_req, i_addr,
        output l_req, l_lock, l_we, l_addr, l_wdata,
        output mem_dout,
        input  d_gnt, d_rvalid, i_gnt, i_rvalid, l_gnt, l_rvalid,
        input  rdata, mem_addr, mem_we, mem_din
    );

endinterface

// File: rtl/m_memarb_prio.sv
// Combinational priority select: D > I > L, starved I jumps D, L owns LOCK.
module m_memarb_prio
    import m_memarb_pkg::*;
(
    input  logic       d_req,
    input  logic       i_req,
    input  logic       l_req,
    input  state_e     state,
    input  logic       starve,
    output logic [2:0] gnt_oh
);

    // Pick exactly one requester (or none) for this cycle.
    always_comb begin
        gnt_oh = '0;
        if (state == ST_LOCK && l_req) begin
            gnt_oh[GNT_L] = 1'b1;
        end else if (i_req && starve) begin
            gnt_oh[GNT_I] = 1'b1;
        end else if (d_req) begin
            gnt_oh[GNT_D] = 1'b1;
        end else if (i_req) begin
            gnt_oh[GNT_I] = 1'b1;
        end else if (l_req && state != ST_HOLDOFF) begin
            gnt_oh[GNT_L] = 1'b1;
        end
    end

endmodule

// File: rtl/m_memarb.sv
// Single-port RAM arbiter for data, fetch and loader ports with burst lock.
module m_memarb
    import m_memarb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned LOCK_MAX   = 16,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_memarb_if.slave   bus,
    output logic        stall_if,
    output logic [31:0] r_conflicts
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_c;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lock_cnt, lock_d;
    logic          starve;
    logic [2:0]    gnt_oh, gnt;
    logic [AW-1:0] addr_q, addr_c;
    logic [DW-1:0] din_c;
    logic          we_c;

    assign starve = (starve_cnt == SW'(STARVE_MAX));

    m_memarb_prio u_prio (
        .d_req  (bus.d_req),
        .i_req  (bus.i_req),
        .l_req  (bus.l_req),
        .state  (state_q),
        .starve (starve),
        .gnt_oh (gnt_oh)
    );

    assign gnt       = w_rst_n ? gnt_oh : 3'b000;
    assign bus.d_gnt = gnt[GNT_D];
    assign bus.i_gnt = gnt[GNT_I];
    assign bus.l_gnt = gnt[GNT_L];
    assign stall_if  = bus.i_req & ~gnt[GNT_I];

    // Route the granted port onto the RAM; idle cycles keep the last address.
    always_comb begin
        addr_c  = addr_q;
        we_c    = 1'b0;
        din_c   = '0;
        owner_c = OWN_NONE;
        if (gnt[GNT_D]) begin
            addr_c  = bus.d_addr;
            we_c    = bus.d_we;
            din_c   = bus.d_wdata;
            owner_c = bus.d_we ? OWN_NONE : OWN_D;
        end else if (gnt[GNT_I]) begin
            addr_c  = bus.i_addr;
            owner_c = OWN_I;
        end else if (gnt[GNT_L]) begin
            addr_c  = bus.l_addr;
            we_c    = bus.l_we;
            din_c   = bus.l_wdata;
            owner_c = bus.l_we ? OWN_NONE : OWN_L;
        end
        if (!w_rst_n) begin
            addr_c = '0;
            we_c   = 1'b0;
            din_c  = '0;
        end
    end

    assign bus.mem_addr = addr_c;
    assign bus.mem_we   = we_c;
    assign bus.mem_din  = din_c;

    // Read data is steered by who issued last cycle's read; reset masks a read in flight.
    assign bus.d_rvalid = w_rst_n && (owner_q == OWN_D);
    assign bus.i_rvalid = w_rst_n && (owner_q == OWN_I);
    assign bus.l_rvalid = w_rst_n && (owner_q == OWN_L);
    assign bus.rdata    = (owner_q != OWN_NONE) ? bus.mem_dout : '0;

    // Address hold register and read-owner register.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            addr_q  <= '0;
            owner_q <= OWN_NONE;
        end else begin
            if (|gnt) addr_q <= addr_c;
            owner_q <= owner_c;
        end
    end

    // FSM state register.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) state_q <= ST_ARB;
        else          state_q <= state_d;
    end

    // Next state and lock counter; the forced release fires on the edge where
    // lock_cnt reaches LOCK_MAX, so L holds the RAM for exactly LOCK_MAX cycles.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_cnt;
        case (state_q)
            ST_ARB: begin
                if (gnt[GNT_L] && bus.l_lock) begin
                    state_d = ST_LOCK;
                    lock_d  = LW'(1);
                end
            end
            ST_LOCK: begin
                lock_d = lock_cnt + LW'(1);
                if (!bus.l_lock) begin
                    state_d = ST_ARB;
                    lock_d  = '0;
                end else if (lock_d == LW'(LOCK_MAX)) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                state_d = ST_ARB;
                lock_d  = '0;
            end
            default: begin
                state_d = ST_ARB;
                lock_d  = '0;
            end
        endcase
    end

    // Starvation, lock and conflict counters.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            starve_cnt  <= '0;
            lock_cnt    <= '0;
            r_conflicts <= '0;
        end else begin
            lock_cnt <= lock_d;
            if (bus.i_req && !gnt[GNT_I]) begin
                if (!starve) starve_cnt <= starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end
            if (multi_req(bus.d_req, bus.i_req, bus.l_req)) begin
                r_conflicts <= r_conflicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_memarb.sv
// Scoreboard bench for m_memarb: stimulus queues expectations, monitor compares.
module tb_m_memarb;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic        stall_if;
    logic [31:0] r_conflicts;

    m_memarb_if #(.AW(12), .DW(32)) bus ();

    m_memarb #(
        .STARVE_MAX (4),
        .LOCK_MAX   (16),
        .AW         (12),
        .DW         (32)
    ) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .bus         (bus),
        .stall_if    (stall_if),
        .r_conflicts (r_conflicts)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [2:0]  gnt;
        logic        stall;
        logic        we;
        logic [11:0] addr;
        logic [31:0] din;
        logic [31:0] conf;
    } exp_t;

    typedef struct {
        logic [2:0]  port;
        logic [31:0] data;
        int          due;
    } rd_t;

    exp_t gq[$];
    rd_t  rq[$];

    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc_n  = 0;
    logic [31:0] exp_conf = '0;
    logic [11:0] last_addr = '0;

    localparam logic [2:0] G0 = 3'b000;
    localparam logic [2:0] GD = 3'b001;
    localparam logic [2:0] GI = 3'b010;
    localparam logic [2:0] GL = 3'b100;

    always @(posedge w_clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        else n_pass++;
    endtask

    // RAM model: write-on-clock, registered read (old data on same-address write).
    logic [31:0] ram [0:4095];
    initial begin
        for (int unsigned a = 0; a < 4096; a++) ram[a] = 32'hA000_0000 | a;
        ram[5] = 32'h2014_000B;
        bus.mem_dout = '0;
        forever begin
            @(posedge w_clk);
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= ram[bus.mem_addr];
        end
    end

    // Queue the expectations for the current cycle, then advance one clock.
    task automatic step(input logic [2:0] eg, input logic [31:0] erd, input bit push_rd);
        exp_t e;
        rd_t  r;
        int   nreq;
        nreq    = int'(bus.d_req) + int'(bus.i_req) + int'(bus.l_req);
        e.gnt   = eg;
        e.stall = bus.i_req & ~eg[1];
        e.we    = 1'b0;
        e.addr  = last_addr;
        e.din   = '0;
        e.conf  = exp_conf;
        if (!w_rst_n) begin
            e.addr = '0;
        end else begin
            case (eg)
                GD: begin e.we = bus.d_we; e.addr = bus.d_addr; e.din = bus.d_wdata; end
                GI: begin e.addr = bus.i_addr; end
                GL: begin e.we = bus.l_we; e.addr = bus.l_addr; e.din = bus.l_wdata; end
                default: ;
            endcase
        end
        gq.push_back(e);
        if (push_rd && eg != G0 && !e.we) begin
            r.port = eg;
            r.data = erd;
            r.due  = cyc_n + 1;
            rq.push_back(r);
        end
        if (!w_rst_n) begin
            exp_conf  = '0;
            last_addr = '0;
        end else begin
            if (nreq >= 2) exp_conf = exp_conf + 32'd1;
            if (eg != G0) last_addr = e.addr;
        end
        @(posedge w_clk);
        #1;
    endtask

    // Monitor: compare queued per-cycle expectations and read returns.
    initial begin
        exp_t        e;
        rd_t         r;
        logic [31:0] rv;
        forever begin
            @(negedge w_clk);
            rv = {29'b0, bus.l_rvalid, bus.i_rvalid, bus.d_rvalid};
            if (gq.size() > 0) begin
                e = gq.pop_front();
                chk("gnt", {29'b0, bus.l_gnt, bus.i_gnt, bus.d_gnt}, {29'b0, e.gnt});
                chk("stall_if", {31'b0, stall_if}, {31'b0, e.stall});
                chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                chk("mem_addr", {20'b0, bus.mem_addr}, {20'b0, e.addr});
                if (e.we || !w_rst_n) chk("mem_din", bus.mem_din, e.din);
                chk("r_conflicts", r_conflicts, e.conf);
            end
            if (rq.size() > 0 && rq[0].due == cyc_n) begin
                r = rq.pop_front();
                chk("rvalid", rv, {29'b0, r.port});
                chk("rdata", bus.rdata, r.data);
            end else begin
                chk("no_rvalid", rv, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic idle_all();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.i_req = 1'b0;
        bus.l_req = 1'b0; bus.l_lock = 1'b0; bus.l_we = 1'b0;
    endtask

    initial begin
        int j;
        logic [2:0] eg;
        w_rst_n = 1'b0;
        idle_all();
        bus.d_addr = '0; bus.d_wdata = '0; bus.i_addr = '0;
        bus.l_addr = '0; bus.l_wdata = '0;
        repeat (2) @(posedge w_clk);
        #1;

        // Reset: grants and RAM controls forced low even with a request pending.
        bus.d_req = 1'b1; bus.d_addr = 12'd7;
        step(G0, '0, 0);
        w_rst_n = 1'b1;
        idle_all();

        // Lone fetch of address 5.
        bus.i_req = 1'b1; bus.i_addr = 12'd5;
        step(GI, 32'h2014_000B, 1);
        idle_all();
        step(G0, '0, 0);

        // D and I contend for 6 cycles: I forced through once starve hits 4.
        bus.d_req = 1'b1; bus.d_addr = 12'h010;
        bus.i_req = 1'b1; bus.i_addr = 12'h011;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) step(GI, 32'hA000_0011, 1);
            else        step(GD, 32'hA000_0010, 1);
        end
        idle_all();
        step(G0, '0, 0);

        // Same-address D write and I read: D first, I then sees the new word.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'd9; bus.d_wdata = 32'h33;
        bus.i_req = 1'b1; bus.i_addr = 12'd9;
        step(GD, '0, 0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step(GI, 32'h0000_0033, 1);
        idle_all();
        step(G0, '0, 0);

        // Locked loader burst with a fetch arriving mid-burst.
        j = 0;
        bus.l_req = 1'b1; bus.l_lock = 1'b1; bus.l_we = 1'b1;
        bus.i_addr = 12'h020;
        for (int k = 0; k < 20; k++) begin
            bus.l_addr  = 12'h100 + 12'(j);
            bus.l_wdata = 32'hC000_0000 | j;
            bus.i_req   = (k >= 10 && k <= 16);
            eg = (k == 16) ? GI : GL;
            step(eg, 32'hA000_0020, 1);
            if (eg == GL) j++;
        end
        idle_all();
        step(G0, '0, 0);
        bus.d_req = 1'b1; bus.d_addr = 12'h110;
        step(GD, 32'hC000_0010, 1);
        idle_all();
        step(G0, '0, 0);

        // Reset with a D read in flight: its rvalid must never appear.
        bus.d_req = 1'b1; bus.d_addr = 12'h030;
        step(GD, '0, 0);
        w_rst_n = 1'b0;
        bus.d_req = 1'b0;
        step(G0, '0, 0);
        w_rst_n = 1'b1;
        bus.d_req = 1'b1;
        step(GD, 32'hA000_0030, 1);
        idle_all();

        // Idle: nothing granted, counters hold.
        repeat (3) step(G0, '0, 0);

        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        chk("read_queue_drained", rq.size(), 32'd0);
        chk("check_queue_drained", gq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
